adc_frame_sched: RTL and testbench

- Capture scheduler between the ADC interface and the byte-wide UART transmitter.
- On start, decimates the ADC sample stream and packs the kept samples into framed byte sequences.
- Writes the bytes into the UART FIFO and honours FIFO backpressure.
- Replaces the ad-hoc sample counter and write-enable logic in the top level. Runs on the ADC SCK domain.

---
 rtl/adc_frame_pkg.sv | 37 +++
 rtl/adc_frame_sched.sv | 193 +++++++++++++++++++
 tb/tb_adc_frame_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg: shared types and constants for the ADC frame scheduler.
//   state_e       - scheduler FSM states (ST_CSUM only with ADC_FRAME_CSUM_EN)
//   byte_t        - UART byte
//   sample_t      - 12-bit ADC sample
//   SYNC_BYTE_DEF - default frame sync byte
//   frame_len()   - bytes per frame for N samples
// Build option: ADC_FRAME_CSUM_EN adds a trailing XOR checksum byte per frame.
package adc_frame_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [11:0] sample_t;

  localparam byte_t SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_WAIT,
    ST_HI,
    ST_LO,
    ST_END
`ifdef ADC_FRAME_CSUM_EN
    , ST_CSUM
`endif
  } state_e;

  // SYNC + SEQ + HI/LO per sample (+ checksum byte when enabled)
  function automatic int unsigned frame_len(input int unsigned n);
`ifdef ADC_FRAME_CSUM_EN
    return 3 + 2 * n;
`else
    return 2 + 2 * n;
`endif
  endfunction

endpackage

// File: rtl/adc_frame_sched.sv
// adc_frame_sched: decimates the ADC sample stream and packs kept samples
// into framed bytes for the UART FIFO, honouring FIFO backpressure.
// Frame: SYNC_BYTE, seq, {HI, LO} x SAMPLES_PER_FRAME [, XOR checksum].
// Build option: ADC_FRAME_CSUM_EN adds the checksum byte (XOR of seq..last LO).
// Ports:
//   clk, rst        - ADC SCK clock, async active-high reset
//   start_i/stop_i  - start continuous framing / stop after current frame
//   adc_data_i, adc_valid_i, adc_error_i - ADC sample stream
//   tx_full_i       - UART FIFO full
//   tx_data_o, tx_wr_en_o - UART byte and write strobe
//   busy_o, overrun_o, frame_seq_o - status
module adc_frame_sched
  import adc_frame_pkg::*;
#(
  parameter int unsigned DECIM             = 2000,
  parameter int unsigned SAMPLES_PER_FRAME = 16,
  parameter byte_t       SYNC_BYTE         = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [11:0] adc_data_i,
  input  logic        adc_valid_i,
  input  logic        adc_error_i,
  input  logic        tx_full_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_en_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [7:0]  frame_seq_o
);

  localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);
  localparam logic [7:0]  SPF_LAST = 8'(SAMPLES_PER_FRAME - 1);

  state_e      state_q, state_d;
  logic [15:0] dcnt_q, dcnt_d;
  sample_t     slot_q, slot_d;
  logic        hold_q, hold_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [7:0]  seq_q, seq_d;
  logic        stop_q, stop_d;
`ifdef ADC_FRAME_CSUM_EN
  byte_t       acc_q, acc_d;
`endif

  logic  busy, keep, emit, wr, lo_wr;
  byte_t tx_byte;

  // Error-flagged samples go through the same path as good ones.
  logic unused_err;
  assign unused_err = adc_error_i;

  assign busy  = (state_q != ST_IDLE);
  assign keep  = busy && adc_valid_i && (dcnt_q == DEC_LAST);
  assign wr    = emit && !tx_full_i;
  assign lo_wr = (state_q == ST_LO) && wr;

  // Byte selection; held on the output while the FIFO is full.
  always_comb begin
    emit    = 1'b0;
    tx_byte = '0;
    case (state_q)
      ST_SYNC: begin emit = 1'b1; tx_byte = SYNC_BYTE;              end
      ST_SEQ:  begin emit = 1'b1; tx_byte = seq_q;                  end
      ST_HI:   begin emit = 1'b1; tx_byte = {4'h0, slot_q[11:8]};   end
      ST_LO:   begin emit = 1'b1; tx_byte = slot_q[7:0];            end
`ifdef ADC_FRAME_CSUM_EN
      ST_CSUM: begin emit = 1'b1; tx_byte = acc_q;                  end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    seq_d   = seq_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_SYNC;
      ST_SYNC: if (wr) state_d = ST_SEQ;
      ST_SEQ: begin
        if (wr) begin
          state_d = ST_WAIT;
          scnt_d  = '0;
        end
      end
      // Leaving on keep as well as hold_q gives the 1-cycle sample->HI latency.
      ST_WAIT: if (hold_q || keep) state_d = ST_HI;
      ST_HI:   if (wr) state_d = ST_LO;
      ST_LO: begin
        if (wr) begin
          if (scnt_q == SPF_LAST) begin
`ifdef ADC_FRAME_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_END;
`endif
          end else begin
            scnt_d  = scnt_q + 8'd1;
            state_d = ST_WAIT;
          end
        end
      end
`ifdef ADC_FRAME_CSUM_EN
      ST_CSUM: if (wr) state_d = ST_END;
`endif
      ST_END: begin
        state_d = stop_q ? ST_IDLE : ST_SYNC;
        seq_d   = seq_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dcnt_d = dcnt_q;
    slot_d = slot_q;
    hold_d = hold_q;
    ovr_d  = ovr_q;
    stop_d = stop_q;

    if (busy && adc_valid_i) dcnt_d = keep ? 16'd0 : dcnt_q + 16'd1;

    if (lo_wr) hold_d = 1'b0;
    // The slot frees in the LO write cycle, so a keep then is accepted.
    if (keep) begin
      if (!hold_q || lo_wr) begin
        slot_d = adc_data_i;
        hold_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (state_q == ST_IDLE && start_i) ovr_d = 1'b0;

    // start+stop together in IDLE arms stop so exactly one frame goes out.
    if (stop_i && (busy || start_i)) stop_d = 1'b1;

    // A sample kept after the last LO of the final frame is discarded.
    if (state_d == ST_IDLE) begin
      dcnt_d = '0;
      hold_d = 1'b0;
      stop_d = 1'b0;
    end
  end

`ifdef ADC_FRAME_CSUM_EN
  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_SYNC)                    acc_d = '0;
    else if (wr && state_q != ST_CSUM)         acc_d = acc_q ^ tx_byte;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      slot_q  <= '0;
      hold_q  <= 1'b0;
      ovr_q   <= 1'b0;
      scnt_q  <= '0;
      seq_q   <= '0;
      stop_q  <= 1'b0;
`ifdef ADC_FRAME_CSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      slot_q  <= slot_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      scnt_q  <= scnt_d;
      seq_q   <= seq_d;
      stop_q  <= stop_d;
`ifdef ADC_FRAME_CSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign tx_data_o   = tx_byte;
  assign tx_wr_en_o  = wr;
  assign busy_o      = busy;
  assign overrun_o   = ovr_q;
  assign frame_seq_o = seq_q;

endmodule

// File: tb/tb_adc_frame_sched.sv
// Directed bench: u0 (DECIM=4, SPF=2) covers framing, backpressure, stop and
// async reset; u1 (DECIM=1, SPF=1) covers overrun and the single-sample frame.
module tb_adc_frame_sched;
  import adc_frame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 0, stop0 = 0, valid0 = 0, full0 = 0;
  logic [11:0] data0 = '0;
  logic [7:0]  txd0, seq0;
  logic        wr0, busy0, ovr0;

  logic        start1 = 0, stop1 = 0, valid1 = 0, full1 = 0;
  logic [11:0] data1 = '0;
  logic [7:0]  txd1, seq1;
  logic        wr1, busy1, ovr1;

  adc_frame_sched #(.DECIM(4), .SAMPLES_PER_FRAME(2)) u0 (
    .clk(clk), .rst(rst), .start_i(start0), .stop_i(stop0),
    .adc_data_i(data0), .adc_valid_i(valid0), .adc_error_i(1'b0),
    .tx_full_i(full0), .tx_data_o(txd0), .tx_wr_en_o(wr0),
    .busy_o(busy0), .overrun_o(ovr0), .frame_seq_o(seq0));

  adc_frame_sched #(.DECIM(1), .SAMPLES_PER_FRAME(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .stop_i(stop1),
    .adc_data_i(data1), .adc_valid_i(valid1), .adc_error_i(1'b0),
    .tx_full_i(full1), .tx_data_o(txd1), .tx_wr_en_o(wr1),
    .busy_o(busy1), .overrun_o(ovr1), .frame_seq_o(seq1));

  byte_t q0[$], q1[$], e[$];
  int nchk = 0, npass = 0;

  // Byte log of every UART write, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && wr0) q0.push_back(txd0);
    if (!rst && wr1) q1.push_back(txd1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input byte_t got[$], input byte_t exp[$]);
    logic [31:0] g;
    chk({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD;
      chk($sformatf("%s[%0d]", tag, i), g, {24'h0, exp[i]});
    end
  endtask

  task automatic vpulse(input int which, input logic [11:0] d);
    if (which == 0) begin valid0 = 1; data0 = d; end
    else            begin valid1 = 1; data1 = d; end
    tick();
    valid0 = 0; valid1 = 0;
    tick();
  endtask

  task automatic wait_idle(input int which, input string tag);
    for (int k = 0; k < 300; k++) begin
      if (((which == 0) ? busy0 : busy1) == 1'b0) break;
      tick();
    end
    chk(tag, (which == 0) ? busy0 : busy1, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst.wr", wr0, 0);   chk("rst.data", txd0, 0);
    chk("rst.busy", busy0, 0); chk("rst.ovr", ovr0, 0);
    chk("rst.seq", seq0, 0);
    rst = 0;
    tick();

    // Frame 1: kept samples are the 4th (ABC) and 8th (678); stop mid-frame.
    start0 = 1; tick(); start0 = 0;
    #2 chk("f1.sync.wr", wr0, 1); chk("f1.sync.data", txd0, 8'hA5);
    chk("f1.busy", busy0, 1);
    begin
      logic [11:0] s [8];
      s = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h012, 12'h345, 12'h678};
      for (int i = 0; i < 8; i++) begin
        stop0 = (i == 2);
        vpulse(0, s[i]);
        stop0 = 0;
      end
    end
    wait_idle(0, "f1.idle");
    e = {8'hA5, 8'h00, 8'h0A, 8'hBC, 8'h06, 8'h78};
`ifdef ADC_FRAME_CSUM_EN
    e.push_back(8'hC8);
`endif
    chk_q("f1", q0, e);
    chk("f1.seq", seq0, 1);

    // Frame 2: FIFO full for 5 cycles while HI is pending; stop mid-frame.
    q0.delete();
    start0 = 1; tick(); start0 = 0;
    vpulse(0, 12'h111); vpulse(0, 12'h222); vpulse(0, 12'h333);
    valid0 = 1; data0 = 12'hDEF; full0 = 1; tick(); valid0 = 0;
    for (int k = 0; k < 5; k++) begin
      #2 chk("full.wr", wr0, 0); chk("full.data", txd0, 8'h0D);
      tick();
    end
    full0 = 0;
    #2 chk("hi.wr", wr0, 1); chk("hi.data", txd0, 8'h0D);
    tick();
    #2 chk("lo.wr", wr0, 1); chk("lo.data", txd0, 8'hEF);
    tick();
    stop0 = 1; tick(); stop0 = 0;
    vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h5A5);
    wait_idle(0, "f2.idle");
    e = {8'hA5, 8'h01, 8'h0D, 8'hEF, 8'h05, 8'hA5};
`ifdef ADC_FRAME_CSUM_EN
    e.push_back(8'h43);
`endif
    chk_q("f2", q0, e);
    chk("f2.seq", seq0, 2);

    // start+stop together in IDLE: exactly one frame.
    q0.delete();
    start0 = 1; stop0 = 1; tick(); start0 = 0; stop0 = 0;
    vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h7FF);
    vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h801);
    wait_idle(0, "f3.idle");
    for (int k = 0; k < 4; k++) vpulse(0, 12'hFFF);
    e = {8'hA5, 8'h02, 8'h07, 8'hFF, 8'h08, 8'h01};
`ifdef ADC_FRAME_CSUM_EN
    e.push_back(8'hF3);
`endif
    chk_q("f3", q0, e);
    chk("f3.seq", seq0, 3);
    chk("f3.busy", busy0, 0);

    // Async reset while the LO byte is on the bus.
    start0 = 1; tick(); start0 = 0;
    vpulse(0, 12'h000); vpulse(0, 12'h000); vpulse(0, 12'h000);
    valid0 = 1; data0 = 12'h9C3; tick(); valid0 = 0;
    tick();
    #2 chk("prelo.wr", wr0, 1); chk("prelo.data", txd0, 8'hC3);
    rst = 1;
    #1 chk("arst.wr", wr0, 0); chk("arst.data", txd0, 0);
    chk("arst.busy", busy0, 0); chk("arst.seq", seq0, 0);
    tick(); rst = 0; tick();
    start0 = 1; tick(); start0 = 0;
    #2 chk("rs.sync.wr", wr0, 1); chk("rs.sync.data", txd0, 8'hA5);
    tick();
    #2 chk("rs.seq.data", txd0, 8'h00);

    // u1: single-sample frame, seq 0, sample ABC.
    q1.delete();
    start1 = 1; stop1 = 1; tick(); start1 = 0; stop1 = 0;
    vpulse(1, 12'hABC);
    wait_idle(1, "u1f1.idle");
    e = {8'hA5, 8'h00, 8'h0A, 8'hBC};
`ifdef ADC_FRAME_CSUM_EN
    e.push_back(8'hB6);
`endif
    chk_q("u1f1", q1, e);

    // u1: FIFO full at SYNC, second kept sample is dropped.
    q1.delete();
    full1 = 1; start1 = 1; tick(); start1 = 0;
    #2 chk("ov.wr", wr1, 0); chk("ov.data", txd1, 8'hA5);
    vpulse(1, 12'h321);
    chk("ov.pre", ovr1, 0);
    vpulse(1, 12'h654);
    chk("ov.set", ovr1, 1);
    stop1 = 1; tick(); stop1 = 0; full1 = 0;
    wait_idle(1, "ov.idle");
    e = {8'hA5, 8'h01, 8'h03, 8'h21};
`ifdef ADC_FRAME_CSUM_EN
    e.push_back(8'h23);
`endif
    chk_q("ov", q1, e);
    chk("ov.sticky", ovr1, 1);
    start1 = 1; tick(); start1 = 0;
    #2 chk("ov.clr", ovr1, 0); chk("ov.busy", busy1, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
